// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit and the data memory it drives.
// Access sizes double as the memory's data_type encoding.
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SIZE_WORD = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_BYTE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } lsu_state_t;

    // Misaligned half/word or the reserved size: the request never reaches memory.
    function automatic logic access_error(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err;
        case (size)
            SIZE_WORD: err = (addr_lo != 2'd0);
            SIZE_HALF: err = addr_lo[0];
            SIZE_BYTE: err = 1'b0;
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/half/word from little-endian memory data and
// sign- or zero-extends it to DATA_W bits.
module load_extend
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data
);

    logic fill_byte_s;
    logic fill_half_s;

    assign fill_byte_s = ~is_unsigned & mem_data_out[7];
    assign fill_half_s = ~is_unsigned & mem_data_out[15];

    // Select the extension mode from the access size.
    always_comb begin
        data = mem_data_out;
        case (size)
            SIZE_BYTE: data = {{24{fill_byte_s}}, mem_data_out[7:0]};
            SIZE_HALF: data = {{16{fill_half_s}}, mem_data_out[15:0]};
            SIZE_WORD: data = mem_data_out;
            default:   data = mem_data_out;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one outstanding load/store at a time, with misaligned
// and reserved-size requests answered by an error response without a memory access.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_data_type,
    input  logic [DATA_W-1:0] mem_data_out
);

    lsu_state_t        state_r;
    lsu_state_t        next_state_s;
    logic              write_r;
    logic [1:0]        size_r;
    logic              unsigned_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic              err_r;
    logic              accept_s;
    logic              req_err_s;
    logic [DATA_W-1:0] load_data_s;

    assign accept_s  = req_valid & req_ready;
    assign req_err_s = access_error(req_size, req_addr[1:0]);

    load_extend u_load_extend (
        .mem_data_out (mem_data_out),
        .size         (size_r),
        .is_unsigned  (unsigned_r),
        .data         (load_data_s)
    );

    // Next-state logic; requests are only seen while idle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    next_state_s = req_err_s ? RESP : ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE:   next_state_s = write_r ? RESP : CAPTURE;
            CAPTURE: next_state_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State, request latch and response register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            write_r    <= 1'b0;
            size_r     <= 2'd0;
            unsigned_r <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            rdata_r    <= '0;
            err_r      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                write_r    <= req_write;
                size_r     <= req_size;
                unsigned_r <= req_unsigned;
                addr_r     <= req_addr;
                wdata_r    <= req_wdata;
                err_r      <= req_err_s;
                rdata_r    <= '0;
            end else if (state_r == CAPTURE) begin
                rdata_r <= load_data_s;
            end
        end
    end

    // Strobes decode from the state register, so reset removes them immediately.
    assign req_ready      = (state_r == IDLE) & ~rst;
    assign resp_valid     = (state_r == RESP);
    assign resp_rdata     = rdata_r;
    assign resp_err       = err_r;
    assign mem_read       = (state_r == ISSUE) & ~write_r;
    assign mem_write      = (state_r == ISSUE) & write_r;
    assign mem_addr       = addr_r;
    assign mem_write_data = wdata_r;
    assign mem_data_type  = size_r;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port. Accepts load/store requests from the core over a valid/ready handshake and drives the synchronous 1 KiB byte-addressed data memory (`MemRead`, `MemWrite`, `data_type`, one-cycle read latency). Rejects misaligned accesses without touching memory. Returns sign- or zero-extended load data, or a store completion, over a valid/ready response channel.

## Interface
- `ADDR_W`, 10: byte address width; matches the data-memory address port.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 0 = word, 1 = half, 2 = byte, 3 = reserved (always an error).
- `req_unsigned` input 1: zero-extend loads; ignored for word accesses and stores.
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: core accepts the response.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: misaligned access or reserved size.
- `mem_addr` output ADDR_W: to data memory `addr`.
- `mem_write_data` output 32: to `write_data`.
- `mem_read` output 1: to `MemRead`.
- `mem_write` output 1: to `MemWrite`.
- `mem_data_type` output 2: to `data_type`; same encoding as `req_size`.
- `mem_data_out` input 32: from `data_out`; little-endian `{a+3, a+2, a+1, a}`.

## Operation
- State machine:
  - IDLE:
    - `req_ready` = 1 only when `rst` = 0.
    - On `req_valid & req_ready`, latch write, size, unsigned, addr and wdata.
    - Legal request → ISSUE. Error → RESP with `resp_err` = 1.
  - ISSUE:
    - Exactly one cycle.
    - `mem_read` = ~write and `mem_write` = write.
    - Store → RESP. Load → CAPTURE.
  - CAPTURE:
    - Memory output is valid in this cycle.
    - Extract, extend, and register the result into `resp_rdata`.
    - Next state is RESP.
  - RESP:
    - `resp_valid` = 1.
    - `resp_rdata` and `resp_err` are held stable until `resp_ready`.
    - On `resp_ready` → IDLE.
- Error conditions:
  - Half access with addr[0] ≠ 0.
  - Word access with addr[1:0] ≠ 0.
  - `req_size` = 3.
  - Errors issue no memory access: `mem_read` and `mem_write` stay 0.
- Alignment guarantees that word and half accesses never wrap past byte 1023.
- Extraction:
  - Byte: `mem_data_out[7:0]`.
  - Half: `mem_data_out[15:0]`.
  - Word: all 32 bits.
  - Byte and half are sign-extended from the top extracted bit unless `req_unsigned` = 1, in which case they are zero-extended.
- Memory-side outputs:
  - `mem_addr`, `mem_write_data` and `mem_data_type` come from the latched registers and are held outside ISSUE.
  - `mem_read` and `mem_write` are 0 in every state except ISSUE.
- Only one request is outstanding at a time. No new request is accepted until the response handshake completes.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready` 0 while `rst` is high, 1 after release.
  - `resp_valid`, `resp_err`, `mem_read`, `mem_write` = 0.
  - `resp_rdata`, `mem_addr`, `mem_write_data` = 0.
  - `mem_data_type` = 0.
- All outputs decode from registered state, so none has a combinational path from `req_*`.
- Load, with the request accepted at edge E0:
  - ISSUE in the cycle after E0.
  - CAPTURE after E1.
  - `resp_valid` high after E2.
  - Minimum request-to-response is 3 cycles.
- Store: `resp_valid` high after E1 (2 cycles). Memory writes at E1.
- Error: `resp_valid` high after E0 (1 cycle).
- Minimum back-to-back throughput:
  - Load: 1 per 4 cycles, with `resp_ready` tied high.
  - Store: 1 per 3 cycles.
- `resp_valid` with `resp_ready` low: stall in RESP indefinitely, with all response outputs stable.
- `req_valid` asserted while not in IDLE: ignored, no acceptance.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - `mem_write` drops asynchronously, so a store in ISSUE may or may not have committed.
  - Pending responses are discarded.

## Structure
- Shared package `lsu_pkg`:
  - Size encodings `SIZE_WORD` = 0, `SIZE_HALF` = 1, `SIZE_BYTE` = 2.
  - State encoding IDLE/ISSUE/CAPTURE/RESP.
  - `DATA_W` = 32.
  - The size encodings are shared with the data memory's `data_type`.
- Sub-module `load_extend`: combinational extract and sign/zero-extend, with inputs `mem_data_out`, size and unsigned. Reused by the pipelined core later.
- The FSM, request latch and response register live in the top module.

## Test plan
Memory is preloaded with bytes 0x010..0x013 = 80 FF 34 12.

- **Loads:** lw 0x010 → `rdata` 0x1234FF80, `err` 0. lh 0x010 → 0xFFFFFF80. lhu 0x010 → 0x0000FF80. lb 0x010 → 0xFFFFFF80. lbu 0x011 → 0x000000FF.
- **Stores:**
  - sb 0x012 data 0xAABBCCDD, then lw 0x010 → 0x12DDFF80.
  - sh 0x020 data 0x0000BEEF, then lhu 0x020 → 0x0000BEEF.
  - Each store responds 2 cycles after acceptance.
- **Errors:** lw 0x011, sh 0x013, and size 3 each give `err` 1 and `rdata` 0 one cycle after acceptance. `mem_read` and `mem_write` stay 0 throughout.
- **Backpressure:** hold `resp_ready` = 0 for 5 cycles after a load. `resp_valid` and `rdata` stay stable, `req_ready` stays 0, and a concurrent `req_valid` is not accepted.
- **Reset during a store:** assert `rst` during ISSUE of a store. `mem_write` falls immediately. After release, `req_ready` = 1, `resp_valid` = 0, and all outputs are at their reset values.
- **Back-to-back:** 8 consecutive lw with `resp_ready` = 1 complete in 32 cycles, with in-order correct data.
